// File: rtl/fb_pkg.sv
// Shared types and constants for the multi-buffer framebuffer.
package fb_pkg;

  typedef logic [1:0] buf_idx_t;

  typedef enum logic [0:0] {
    RENDER    = 1'b0,
    WAIT_SWAP = 1'b1
  } fb_state_e;

  localparam logic [15:0] DROP_MAX    = 16'hFFFF;
  localparam int          FB_MAX_BUFS = 3;

endpackage

// File: rtl/fb_bank_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered output.
// Read data appears one cycle after raddr is presented; no backpressure.
module fb_bank_ram #(
  parameter int DEPTH = 1024,
  parameter int DW    = 3,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/framebuffer_multibuf.sv
// Double/triple-buffered framebuffer between renderer and display with handshaken rotation.
// Read data 1 cycle after address; renderer is held off via render_done/render_ack.
module framebuffer_multibuf
  import fb_pkg::*;
#(
  parameter int WIDTH      = 320,
  parameter int HEIGHT     = 240,
  parameter int COLOR_BITS = 3,
  parameter int NUM_BUFS   = 2,
  parameter int XW         = $clog2(WIDTH),
  parameter int YW         = $clog2(HEIGHT)
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  new_frame,
  input  logic [XW-1:0]         out_x,
  input  logic [YW-1:0]         out_y,
  output logic [COLOR_BITS-1:0] color_out,
  input  logic [XW-1:0]         wr_x,
  input  logic [YW-1:0]         wr_y,
  input  logic [COLOR_BITS-1:0] color_in,
  input  logic                  we,
  input  logic                  render_done,
  output logic                  render_ack,
  output logic [1:0]            front_idx,
  output logic [15:0]           drop_count
);

  localparam int FRAME = WIDTH * HEIGHT;
  localparam int DEPTH = NUM_BUFS * FRAME;
  localparam int AW    = $clog2(DEPTH);

  generate
    if (NUM_BUFS < 2 || NUM_BUFS > FB_MAX_BUFS) begin : g_bad_bufs
      $error("framebuffer_multibuf: NUM_BUFS must be 2 or 3");
    end
  endgenerate

  fb_state_e state_q, state_d;
  buf_idx_t  front_q, front_d, back_q, back_d, spare_q, spare_d, ready_q, ready_d;
  logic      rv_q, rv_d, ack_q, ack_d, rd_ok_q, rd_ok_d;
  logic [15:0] drop_q, drop_d;

  logic                  take_done, wr_in_range, wr_en;
  logic [AW-1:0]         wr_addr, rd_addr;
  logic [COLOR_BITS-1:0] ram_rdata;

  // A done seen while ack is still high belongs to the handshake just completed.
  assign take_done = render_done && !ack_q;

  always_comb begin
    state_d = state_q;
    front_d = front_q;
    back_d  = back_q;
    spare_d = spare_q;
    ready_d = ready_q;
    rv_d    = rv_q;
    drop_d  = drop_q;
    ack_d   = 1'b0;
    if (NUM_BUFS == 2) begin
      case (state_q)
        RENDER: begin
          if (take_done) begin
            if (new_frame) begin
              front_d = back_q;
              back_d  = front_q;
              ack_d   = 1'b1;
            end else begin
              state_d = WAIT_SWAP;
            end
          end
        end
        WAIT_SWAP: begin
          if (new_frame) begin
            front_d = back_q;
            back_d  = front_q;
            ack_d   = 1'b1;
            state_d = RENDER;
          end
        end
        default: state_d = RENDER;
      endcase
    end else begin
      // Display side first, so a same-cycle done sees the freed buffer as spare.
      if (new_frame && rv_q) begin
        front_d = ready_q;
        spare_d = front_q;
        rv_d    = 1'b0;
      end
      if (take_done) begin
        ack_d = 1'b1;
        if (rv_d) begin
          ready_d = back_q;
          back_d  = ready_q;
          spare_d = back_q;
          drop_d  = (drop_q == DROP_MAX) ? DROP_MAX : drop_q + 16'd1;
        end else begin
          ready_d = back_q;
          back_d  = spare_d;
          spare_d = back_q;
          rv_d    = 1'b1;
        end
      end
    end
  end

  assign wr_in_range = (int'(wr_x) < WIDTH) && (int'(wr_y) < HEIGHT);
  assign wr_en       = we && wr_in_range && (state_q != WAIT_SWAP);
  assign wr_addr     = wr_in_range ?
                       AW'(int'(back_q) * FRAME + int'(wr_y) * WIDTH + int'(wr_x)) : '0;
  assign rd_ok_d     = (int'(out_x) < WIDTH) && (int'(out_y) < HEIGHT);
  assign rd_addr     = rd_ok_d ?
                       AW'(int'(front_q) * FRAME + int'(out_y) * WIDTH + int'(out_x)) : '0;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= RENDER;
      front_q <= 2'd0;
      back_q  <= 2'd1;
      spare_q <= 2'd2;
      ready_q <= 2'd0;
      rv_q    <= 1'b0;
      ack_q   <= 1'b0;
      drop_q  <= 16'd0;
      rd_ok_q <= 1'b0;
    end else begin
      state_q <= state_d;
      front_q <= front_d;
      back_q  <= back_d;
      spare_q <= spare_d;
      ready_q <= ready_d;
      rv_q    <= rv_d;
      ack_q   <= ack_d;
      drop_q  <= drop_d;
      rd_ok_q <= rd_ok_d;
    end
  end

  fb_bank_ram #(
    .DEPTH(DEPTH),
    .DW   (COLOR_BITS),
    .AW   (AW)
  ) u_ram (
    .clk  (Clk),
    .we   (wr_en),
    .waddr(wr_addr),
    .wdata(color_in),
    .raddr(rd_addr),
    .rdata(ram_rdata)
  );

  assign color_out  = rd_ok_q ? ram_rdata : '0;
  assign render_ack = ack_q;
  assign front_idx  = front_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_framebuffer_multibuf.sv
// Directed bench for framebuffer_multibuf: one double- and one triple-buffered instance.
module tb_framebuffer_multibuf;

  localparam int W  = 10;
  localparam int H  = 12;
  localparam int XW = 4;
  localparam int YW = 4;

  logic          Clk = 1'b0;
  logic          Reset;
  logic [XW-1:0] out_x, wr_x;
  logic [YW-1:0] out_y, wr_y;
  logic [2:0]    color_in;
  logic          we_d, done_d, nf_d;
  logic          we_t, done_t, nf_t;
  logic [2:0]    col_d, col_t;
  logic          ack_d, ack_t;
  logic [1:0]    fidx_d, fidx_t;
  logic [15:0]   drop_d, drop_t;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  framebuffer_multibuf #(.WIDTH(W), .HEIGHT(H), .COLOR_BITS(3), .NUM_BUFS(2)) u_dbl (
    .Clk(Clk), .Reset(Reset), .new_frame(nf_d), .out_x(out_x), .out_y(out_y),
    .color_out(col_d), .wr_x(wr_x), .wr_y(wr_y), .color_in(color_in), .we(we_d),
    .render_done(done_d), .render_ack(ack_d), .front_idx(fidx_d), .drop_count(drop_d)
  );

  framebuffer_multibuf #(.WIDTH(W), .HEIGHT(H), .COLOR_BITS(3), .NUM_BUFS(3)) u_tri (
    .Clk(Clk), .Reset(Reset), .new_frame(nf_t), .out_x(out_x), .out_y(out_y),
    .color_out(col_t), .wr_x(wr_x), .wr_y(wr_y), .color_in(color_in), .we(we_t),
    .render_done(done_t), .render_ack(ack_t), .front_idx(fidx_t), .drop_count(drop_t)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wr_pix(input bit tri_sel, input int x, input int y, input int c);
    wr_x = XW'(x); wr_y = YW'(y); color_in = 3'(c);
    if (tri_sel) we_t = 1'b1; else we_d = 1'b1;
    tick();
    we_t = 1'b0; we_d = 1'b0;
  endtask

  task automatic rd_pix(input string tag, input bit tri_sel, input int x, input int y,
                        input int exp);
    out_x = XW'(x); out_y = YW'(y);
    tick();
    chk(tag, tri_sel ? int'(col_t) : int'(col_d), exp);
  endtask

  task automatic dbl_swap();
    done_d = 1'b1; tick();
    nf_d = 1'b1;   tick();
    nf_d = 1'b0; done_d = 1'b0; tick();
  endtask

  task automatic tri_done(input string tag);
    done_t = 1'b1; tick();
    done_t = 1'b0;
    chk({tag, "_ack"}, int'(ack_t), 1);
    tick();
    chk({tag, "_ack_low"}, int'(ack_t), 0);
  endtask

  initial begin
    Reset = 1'b1; out_x = '0; out_y = '0; wr_x = '0; wr_y = '0; color_in = '0;
    we_d = 0; done_d = 0; nf_d = 0; we_t = 0; done_t = 0; nf_t = 0;
    tick(); tick();
    Reset = 1'b0;
    chk("rst_front_d", int'(fidx_d), 0);
    chk("rst_ack_d",   int'(ack_d), 0);
    chk("rst_color_d", int'(col_d), 0);
    chk("rst_front_t", int'(fidx_t), 0);
    chk("rst_drop_t",  int'(drop_t), 0);

    // 1: basic double-buffer handshake
    wr_pix(0, 5, 7, 5);
    done_d = 1'b1; tick();
    chk("t1_ack_pre", int'(ack_d), 0);
    nf_d = 1'b1; tick();
    nf_d = 1'b0;
    chk("t1_ack", int'(ack_d), 1);
    chk("t1_front", int'(fidx_d), 1);
    done_d = 1'b0; tick();
    chk("t1_ack_once", int'(ack_d), 0);
    rd_pix("t1_read", 0, 5, 7, 5);

    // 2: done held, writes in WAIT_SWAP dropped (back = 0)
    wr_pix(0, 2, 3, 3);
    wr_pix(0, 4, 4, 1);
    done_d = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 2) begin wr_x = 4'd2; wr_y = 4'd3; color_in = 3'd6; we_d = 1'b1; end
      if (i == 3) begin wr_x = 4'd4; wr_y = 4'd4; color_in = 3'd7; end
      if (i == 4) we_d = 1'b0;
      tick();
      chk("t2_ack_hold", int'(ack_d), 0);
    end
    nf_d = 1'b1; tick();
    nf_d = 1'b0; done_d = 1'b0;
    chk("t2_ack", int'(ack_d), 1);
    chk("t2_front", int'(fidx_d), 0);
    tick();
    rd_pix("t2_keep_a", 0, 2, 3, 3);
    rd_pix("t2_keep_b", 0, 4, 4, 1);

    // 5: out-of-range accesses (back = 1, front = 0)
    wr_pix(0, 0, 3, 2);
    wr_pix(0, W, 2, 7);
    wr_pix(0, 0, H, 7);
    rd_pix("t5_inrange", 0, 4, 4, 1);
    rd_pix("t5_rd_xw", 0, W, 3, 0);
    rd_pix("t5_rd_yh", 0, 4, H, 0);
    rd_pix("t5_rd_alias", 0, 14, 3, 0);
    dbl_swap();
    chk("t5_front", int'(fidx_d), 1);
    rd_pix("t5_no_alias_wr", 0, 0, 3, 2);

    // 3: triple buffering, three frames without display
    wr_pix(1, 1, 1, 1);
    tri_done("t3_a");
    wr_pix(1, 1, 1, 2);
    tri_done("t3_b");
    wr_pix(1, 1, 1, 3);
    tri_done("t3_c");
    chk("t3_drop", int'(drop_t), 2);
    chk("t3_front0", int'(fidx_t), 0);
    nf_t = 1'b1; tick(); nf_t = 1'b0;
    chk("t3_front1", int'(fidx_t), 1);
    rd_pix("t3_read", 1, 1, 1, 3);

    // 4: same-cycle new_frame and done with a ready frame pending
    wr_pix(1, 2, 2, 4);
    tri_done("t4_d");
    wr_pix(1, 2, 2, 5);
    done_t = 1'b1; nf_t = 1'b1; tick();
    done_t = 1'b0; nf_t = 1'b0;
    chk("t4_ack", int'(ack_t), 1);
    chk("t4_drop", int'(drop_t), 2);
    chk("t4_front", int'(fidx_t), 2);
    rd_pix("t4_old_ready", 1, 2, 2, 4);
    nf_t = 1'b1; tick(); nf_t = 1'b0;
    chk("t4_front_next", int'(fidx_t), 0);
    rd_pix("t4_new_ready", 1, 2, 2, 5);

    // 6: reset while waiting for the swap
    done_d = 1'b1; tick();
    Reset = 1'b1; tick();
    Reset = 1'b0; done_d = 1'b0;
    chk("t6_front", int'(fidx_d), 0);
    chk("t6_ack", int'(ack_d), 0);
    chk("t6_drop_t", int'(drop_t), 0);
    chk("t6_front_t", int'(fidx_t), 0);
    nf_d = 1'b1; tick(); nf_d = 1'b0;
    chk("t6_no_ack", int'(ack_d), 0);
    chk("t6_no_swap", int'(fidx_d), 0);
    tick();
    chk("t6_no_ack2", int'(ack_d), 0);
    dbl_swap();
    chk("t6_fresh_swap", int'(fidx_d), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
